// File: rtl/uart_tx_mport.sv
// Multi-port memory-mapped UART transmitter: up to NPORTS byte stores per cycle
// are queued in a DEPTH-entry FIFO and sent as contiguous 8N1 frames on uart_tx.
module uart_tx_mport #(
   parameter int NPORTS = 2,
   parameter int DEPTH  = 16,
   parameter int DIV    = 868
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NPORTS-1:0]          wr_en,
   input  logic [8*NPORTS-1:0]        wr_data,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy,
   output logic                       overflow,
   output logic                       uart_tx
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int DW = $clog2(DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} TxState;

   TxState            r_state;
   TxState            w_nextState;
   logic [7:0]        r_mem [DEPTH];
   logic [AW-1:0]     r_head;
   logic [AW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic              r_full;
   logic              r_overflow;
   logic              r_tx;
   logic [7:0]        r_sh;
   logic [2:0]        r_bitCnt;
   logic [DW-1:0]     r_div;

   logic              w_pop;
   logic              w_txNext;
   logic [2:0]        w_bitNext;
   logic [DW-1:0]     w_divNext;
   logic              w_divEnd;
   logic [CW-1:0]     w_free;
   logic [CW-1:0]     w_acc;
   logic [CW-1:0]     w_countNext;
   logic              w_drop;
   logic [NPORTS-1:0] w_wrOk;
   logic [AW-1:0]     w_wrAddr [NPORTS];

   assign w_divEnd = (r_div == DW'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_nextState;
   end

   // A pop happens on leaving IDLE or at the end of STOP, so frames chain with no gap
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      w_txNext    = r_tx;
      w_bitNext   = r_bitCnt;
      w_divNext   = r_div + DW'(1);
      unique case (r_state)
         IDLE: begin
            w_divNext = '0;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_txNext    = 1'b0;
               w_nextState = START;
            end
         end
         START: begin
            if (w_divEnd) begin
               w_divNext   = '0;
               w_bitNext   = '0;
               w_txNext    = r_sh[0];
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_divEnd) begin
               w_divNext = '0;
               if (r_bitCnt == 3'd7) begin
                  w_txNext    = 1'b1;
                  w_nextState = STOP;
               end else begin
                  w_bitNext = r_bitCnt + 3'd1;
                  w_txNext  = r_sh[r_bitCnt + 3'd1];
               end
            end
         end
         STOP: begin
            if (w_divEnd) begin
               w_divNext = '0;
               if (r_count != '0) begin
                  w_pop       = 1'b1;
                  w_txNext    = 1'b0;
                  w_nextState = START;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Lower ports claim free slots first; a slot freed by this cycle's pop is usable
   always_comb begin
      w_free = CW'(DEPTH) - r_count + CW'(w_pop);
      w_acc  = '0;
      w_drop = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         w_wrOk[i]   = 1'b0;
         w_wrAddr[i] = r_tail + w_acc[AW-1:0];
         if (wr_en[i]) begin
            if (w_acc < w_free) begin
               w_wrOk[i] = 1'b1;
               w_acc     = w_acc + CW'(1);
            end else begin
               w_drop = 1'b1;
            end
         end
      end
      w_countNext = r_count + w_acc - CW'(w_pop);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NPORTS; i++) begin
         if (w_wrOk[i]) r_mem[w_wrAddr[i]] <= wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
         r_tx       <= 1'b1;
         r_sh       <= '0;
         r_bitCnt   <= '0;
         r_div      <= '0;
      end else begin
         if (w_pop) begin
            r_sh   <= r_mem[r_head];
            r_head <= r_head + AW'(1);
         end
         r_tail     <= r_tail + w_acc[AW-1:0];
         r_count    <= w_countNext;
         r_full     <= (w_countNext > CW'(DEPTH - NPORTS));
         r_overflow <= r_overflow | w_drop;
         r_tx       <= w_txNext;
         r_bitCnt   <= w_bitNext;
         r_div      <= w_divNext;
      end
   end

   assign full     = r_full;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign uart_tx  = r_tx;
   assign busy     = (r_state != IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_tx_mport.sv
// Bench for uart_tx_mport (DIV=4, DEPTH=4, NPORTS=2): directed steps push expected
// bytes to a scoreboard, and a serial receiver pops and compares each decoded frame.
module tb_uart_tx_mport;
   localparam int NPORTS = 2;
   localparam int DEPTH  = 4;
   localparam int DIV    = 4;

   logic        clk;
   logic        rst;
   logic [1:0]  wrEn;
   logic [15:0] wrData;
   logic        full;
   logic [2:0]  count;
   logic        busy;
   logic        overflow;
   logic        uartTx;

   int          nChecks = 0;
   int          nFail   = 0;
   int          issued;
   logic [7:0]  sb [$];

   uart_tx_mport #(.NPORTS(NPORTS), .DEPTH(DEPTH), .DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wrEn),
      .wr_data  (wrData),
      .full     (full),
      .count    (count),
      .busy     (busy),
      .overflow (overflow),
      .uart_tx  (uartTx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
         else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         end
   endtask

   // Drives one cycle of writes from a negedge; returns at the negedge after the sampling edge
   task automatic applyStimulus(input logic [1:0] en, input logic [15:0] data);
      wrEn   = en;
      wrData = data;
      @(negedge clk);
      wrEn   = 2'b00;
   endtask

   task automatic applyReset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic waitIdle(input int budget);
      for (int c = 0; c < budget && busy !== 1'b0; c++) @(negedge clk);
      checkOutput("idleTimeout", busy, 0);
      checkOutput("sbEmpty", sb.size(), 0);
   endtask

   // Serial receiver: samples mid-bit, ignores frames cut short by reset
   initial begin : rxMonitor
      logic [9:0] bits;
      logic       aborted;
      logic [7:0] expByte;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && uartTx === 1'b0) begin
            aborted = 1'b0;
            bits    = '0;
            for (int c = 1; c < 10*DIV; c++) begin
               @(negedge clk);
               if (rst !== 1'b1) aborted = 1'b1;
               if (c % DIV == DIV/2) bits[c/DIV] = uartTx;
            end
            if (!aborted) begin
               checkOutput("startBit", bits[0], 0);
               checkOutput("stopBit", bits[9], 1);
               checkOutput("frameExpected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  expByte = sb.pop_front();
                  checkOutput("rxByte", bits[8:1], expByte);
               end
            end
         end
      end
   end

   initial begin
      rst    = 1'b0;
      wrEn   = 2'b00;
      wrData = '0;
      @(negedge clk);
      checkOutput("rstTx", uartTx, 1);
      checkOutput("rstCount", count, 0);
      checkOutput("rstFull", full, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstOverflow", overflow, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte: latency to start bit and busy duration
      sb.push_back(8'h55);
      applyStimulus(2'b01, 16'h0055);
      checkOutput("t1CountE0", count, 1);
      checkOutput("t1TxE0", uartTx, 1);
      checkOutput("t1BusyE0", busy, 1);
      @(negedge clk);
      checkOutput("t1TxE1", uartTx, 0);
      checkOutput("t1CountE1", count, 0);
      repeat (39) @(negedge clk);
      checkOutput("t1BusyE40", busy, 1);
      checkOutput("t1StopE40", uartTx, 1);
      @(negedge clk);
      checkOutput("t1BusyE41", busy, 0);

      // Dual write, frames must be contiguous
      sb.push_back(8'h41);
      sb.push_back(8'h42);
      applyStimulus(2'b11, 16'h4241);
      checkOutput("t2CountE0", count, 2);
      checkOutput("t2Overflow", overflow, 0);
      @(negedge clk);
      checkOutput("t2CountE1", count, 1);
      checkOutput("t2TxE1", uartTx, 0);
      repeat (39) @(negedge clk);
      checkOutput("t2StopE40", uartTx, 1);
      @(negedge clk);
      checkOutput("t2NoGapE41", uartTx, 0);
      checkOutput("t2CountE41", count, 0);
      waitIdle(200);

      // Fill to DEPTH while sending, then an overflowing dual write
      sb.push_back(8'h10);
      applyStimulus(2'b01, 16'h0010);
      @(negedge clk);
      applyStimulus(2'b11, 16'h0201);
      checkOutput("t3Count2", count, 2);
      checkOutput("t3Full2", full, 0);
      applyStimulus(2'b11, 16'h0403);
      checkOutput("t3Count4", count, 4);
      checkOutput("t3Full4", full, 1);
      applyStimulus(2'b11, 16'h0605);
      checkOutput("t3CountDrop", count, 4);
      checkOutput("t3Overflow", overflow, 1);
      sb.push_back(8'h01);
      sb.push_back(8'h02);
      sb.push_back(8'h03);
      sb.push_back(8'h04);
      waitIdle(400);
      checkOutput("t3OverflowSticky", overflow, 1);
      applyReset();
      checkOutput("t3OverflowReset", overflow, 0);

      // count=3 with a pop in the same cycle: both ports fit
      sb.push_back(8'h20);
      sb.push_back(8'h21);
      sb.push_back(8'h22);
      sb.push_back(8'h23);
      sb.push_back(8'h24);
      sb.push_back(8'h25);
      applyStimulus(2'b01, 16'h0020);
      applyStimulus(2'b11, 16'h2221);
      checkOutput("t4aCount2", count, 2);
      applyStimulus(2'b01, 16'h0023);
      checkOutput("t4aCount3", count, 3);
      repeat (38) @(negedge clk);
      applyStimulus(2'b11, 16'h2524);
      checkOutput("t4aCountPop", count, 4);
      checkOutput("t4aFull", full, 1);
      checkOutput("t4aOverflow", overflow, 0);
      waitIdle(400);
      applyReset();

      // count=3 without a pop: only port 0 fits
      sb.push_back(8'h40);
      sb.push_back(8'h41);
      sb.push_back(8'h42);
      sb.push_back(8'h43);
      sb.push_back(8'h30);
      applyStimulus(2'b01, 16'h0040);
      applyStimulus(2'b11, 16'h4241);
      applyStimulus(2'b01, 16'h0043);
      checkOutput("t4bCount3", count, 3);
      applyStimulus(2'b11, 16'h3130);
      checkOutput("t4bCount4", count, 4);
      checkOutput("t4bOverflow", overflow, 1);
      waitIdle(400);
      applyReset();

      // Asynchronous reset during data bit 3 of 0x35 (bit value 0)
      applyStimulus(2'b01, 16'h0035);
      applyStimulus(2'b11, 16'h0201);
      repeat (17) @(negedge clk);
      checkOutput("t5TxBit3", uartTx, 0);
      checkOutput("t5CountPre", count, 2);
      #2 rst = 1'b0;
      #1;
      checkOutput("t5TxAsync", uartTx, 1);
      checkOutput("t5CountAsync", count, 0);
      checkOutput("t5BusyAsync", busy, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      sb.push_back(8'hA5);
      applyStimulus(2'b01, 16'h00A5);
      waitIdle(200);
      checkOutput("t5Overflow", overflow, 0);

      // Full-throttle dual writes gated by full
      issued = 0;
      for (int c = 0; c < 20000 && issued < 100; c++) begin
         if (full === 1'b0) begin
            wrEn   = 2'b11;
            wrData = {8'(issued * 7 + 10), 8'(issued * 7 + 3)};
            sb.push_back(8'(issued * 7 + 3));
            sb.push_back(8'(issued * 7 + 10));
            issued += 2;
         end else begin
            wrEn = 2'b00;
         end
         @(negedge clk);
      end
      wrEn = 2'b00;
      checkOutput("t6Issued", issued, 100);
      waitIdle(8000);
      checkOutput("t6Overflow", overflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/uart_tx_mport.md
Name: uart_tx_mport

Overview:
- Parametrised successor to the single-byte memory-mapped UART transmitter used by the dual-issue core.
- Accepts up to NPORTS byte writes in the same cycle; both issue slots may store to the UART address together without losing a byte.
- Buffers bytes in a DEPTH-entry FIFO and serialises them as 8N1 frames on uart_tx.
- Exports full, for pipeline stall, and a sticky overflow flag.

Parameters:
- NPORTS, 2, number of write ports; port 0 has priority and is the older instruction.
- DEPTH, 16, FIFO entries; power of two, at least NPORTS.
- DIV, 868, clock cycles per bit (100 MHz / 115200); at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; rst is asynchronous and active-low; clock is clk.
- wr_en  in  NPORTS  per-port byte write strobe.
- wr_data  in  8*NPORTS  port i byte at [8i+7:8i].
- full  out  1  fewer than NPORTS free entries.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- overflow  out  1  sticky: a write was dropped.
- uart_tx  out  1  serial line, idle high.

Behaviour:
Reset (rst low, asynchronous):
- uart_tx=1, count=0, full=0, busy=0, overflow=0.
- FSM=IDLE; head, tail, bit counter and divider counter all 0.
- Reset mid-frame aborts the frame immediately, drives uart_tx high and discards the FIFO contents.

Enqueue:
- All enabled ports are sampled on the same posedge.
- Bytes are placed in ascending port order at consecutive tail slots.
- Accept at most free = DEPTH - count + pop bytes, where pop=1 if the FSM dequeues in that same cycle.
- Lower-index ports are accepted first. Excess enabled ports are dropped, and overflow is set on the next edge.
- overflow clears only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count_next = count + accepted - pop; count never exceeds DEPTH.

full:
- Registered; full = (DEPTH - count) < NPORTS, evaluated from the post-update count.

FSM states: IDLE, START, DATA, STOP.
- IDLE: if count>0, pop the head into shift register sh, set uart_tx=0, go to START.
- START: hold uart_tx=0 for DIV cycles total, then uart_tx=sh[0] and go to DATA.
- DATA: 8 bits, LSB first, each held DIV cycles. After bit 7, uart_tx=1 and go to STOP.
- STOP: hold 1 for DIV cycles. At the end, if count>0, pop and go directly to START with uart_tx=0, giving no idle gap. Otherwise go to IDLE.
- Frame length is exactly 10*DIV cycles; back-to-back frames are contiguous.
- The divider counts 0..DIV-1 and reloads at each bit boundary.

Latency:
- A byte written at edge E0 into an empty FIFO with the FSM in IDLE drives uart_tx low at edge E1.

Simultaneous events:
- Push and pop in the same cycle are legal, with net count change as above.
- Writes accepted while full=1 still succeed if the actual free space suffices. full is advisory: the pipeline must stall on it, and the block never corrupts data.

busy:
- busy = (FSM != IDLE) || (count != 0).

Test Plan:
1. DIV=4, DEPTH=4, NPORTS=2. Write 0x55 on port 0 at E0 -> uart_tx: 1 until E1, then 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4. busy falls at E41 (10*4 cycles after E1).
2. Same cycle, port0=0x41 and port1=0x42 -> two contiguous frames, 'A' then 'B'. count=2 after E0, then 1 after E1. No idle cycle between frames. overflow=0.
3. DEPTH=4, FSM busy with an empty FIFO. Write two pairs (0x01,0x02) then (0x03,0x04) -> count=4, full=1. A third dual write (0x05,0x06) with no pop that cycle -> both dropped, overflow=1, and subsequent frames carry 01,02,03,04 only.
4. count=3, DEPTH=4: dual write in the cycle the FSM pops -> both accepted, count=4. Same write without a pop -> port0 accepted, port1 dropped, overflow=1.
5. Assert rst low mid-DATA (bit 3) -> uart_tx=1 and count=0 asynchronously. After release, a new write of 0xA5 produces one clean frame.
6. Continuous dual writes at full throttle, gated by full, over 100 bytes -> the received byte stream is identical to the issued stream in port/cycle order, and overflow stays 0.
